sample_pingpong_buffer: RTL and testbench

//  Frame buffer between the audio codec sample stream and the FFT front end.
//  - Splits each 512-sample frame into even-index and odd-index banks (radix-2 split).
//  - Raises full_even/full_odd for the FFT controller.
//  - When the controller asserts read, streams the frame back in original order, one sample per cycle.
//  - It is the write/fill side of the full_*/write_*/read handshake the FFT controller drives.

---
 rtl/music_sampler_pkg.sv | 9 +
 rtl/sample_bank_ram.sv | 27 ++
 rtl/sample_pingpong_buffer.sv | 130 +++++++++++++
 tb/tb_sample_pingpong_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/music_sampler_pkg.sv
// rtl/music_sampler_pkg.sv - shared sample/frame defaults and buffer state type
package music_sampler_pkg;
  localparam int DEF_SAMPLE_W  = 16;
  localparam int DEF_FRAME_LEN = 512;

  typedef enum logic [1:0] {FILL, FULL, DRAIN} buf_state_t;

  typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sample_bank_ram.sv
// rtl/sample_bank_ram.sv - one half-frame bank, 1 write port, 1 registered read port
module sample_bank_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register only updates on a read so the streamed value holds while paused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sample_pingpong_buffer.sv
// rtl/sample_pingpong_buffer.sv - even/odd split frame buffer feeding the FFT front end
// Optional dropped-sample counter enabled by SPB_DROP_CNT_EN.
module sample_pingpong_buffer
  import music_sampler_pkg::*;
#(
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  localparam int IDX_W    = $clog2(FRAME_LEN)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  input  logic                       write_even,
  input  logic                       write_odd,
  input  logic                       read,
  output logic                       full_even,
  output logic                       full_odd,
  output logic signed [SAMPLE_W-1:0] rd_data,
  output logic [IDX_W-1:0]           rd_index,
  output logic                       rd_valid
`ifdef SPB_DROP_CNT_EN
  ,
  output logic [15:0]                drop_count
`endif
);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(FRAME_LEN - 2);

  buf_state_t          state;
  logic [IDX_W-1:0]    wr_ptr;
  logic [IDX_W-1:0]    rd_ptr;
  logic                rd_sel;
  logic [SAMPLE_W-1:0] even_q;
  logic [SAMPLE_W-1:0] odd_q;
  logic                accept;
  logic                issue;

  // Bank enable follows the pointer parity so a refused sample never skews pairing.
  assign accept = (state == FILL) && sample_valid && (wr_ptr[0] ? write_odd : write_even);
  assign issue  = (state == DRAIN) && read;

  sample_bank_ram #(.DATA_W(SAMPLE_W), .DEPTH(FRAME_LEN/2)) u_even_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept && !wr_ptr[0]),
    .wr_addr (wr_ptr[IDX_W-1:1]),
    .wr_data (sample_in),
    .rd_en   (issue && !rd_ptr[0]),
    .rd_addr (rd_ptr[IDX_W-1:1]),
    .rd_data (even_q)
  );

  sample_bank_ram #(.DATA_W(SAMPLE_W), .DEPTH(FRAME_LEN/2)) u_odd_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept && wr_ptr[0]),
    .wr_addr (wr_ptr[IDX_W-1:1]),
    .wr_data (sample_in),
    .rd_en   (issue && rd_ptr[0]),
    .rd_addr (rd_ptr[IDX_W-1:1]),
    .rd_data (odd_q)
  );

  assign rd_data = rd_sel ? odd_q : even_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      full_even <= 1'b0;
      full_odd  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_index  <= '0;
      rd_sel    <= 1'b0;
    end else begin
      rd_valid <= issue;
      if (issue) begin
        rd_index <= rd_ptr;
        rd_sel   <= rd_ptr[0];
      end
      case (state)
        FILL: begin
          if (accept) begin
            if (wr_ptr == PENULT_IDX) full_even <= 1'b1;
            if (wr_ptr == LAST_IDX) begin
              full_odd <= 1'b1;
              wr_ptr   <= '0;
              state    <= FULL;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        FULL: begin
          if (read) begin
            state  <= DRAIN;
            rd_ptr <= '0;
          end
        end
        DRAIN: begin
          if (read) begin
            if (rd_ptr == LAST_IDX) begin
              state     <= FILL;
              full_even <= 1'b0;
              full_odd  <= 1'b0;
              wr_ptr    <= '0;
              rd_ptr    <= '0;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef SPB_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_count <= '0;
    else if (sample_valid && !accept && (drop_count != 16'hFFFF))
      drop_count <= drop_count + 16'd1;
  end
`else
  // Without the counter, refused strobes leave no trace.
`endif
endmodule

// File: tb/tb_sample_pingpong_buffer.sv
// tb/tb_sample_pingpong_buffer.sv - scoreboard bench with frame-level reference model
module tb_sample_pingpong_buffer;
  localparam int SW = 16;
  localparam int FL = 512;
  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] sample_in;
  logic          sample_valid;
  logic          write_even;
  logic          write_odd;
  logic          read;
  logic          full_even;
  logic          full_odd;
  logic [SW-1:0] rd_data;
  logic [IW-1:0] rd_index;
  logic          rd_valid;
`ifdef SPB_DROP_CNT_EN
  logic [15:0]   drop_count;
`endif

  sample_pingpong_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .write_even   (write_even),
    .write_odd    (write_odd),
    .read         (read),
    .full_even    (full_even),
    .full_odd     (full_odd),
    .rd_data      (rd_data),
    .rd_index     (rd_index),
    .rd_valid     (rd_valid)
`ifdef SPB_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: 0=filling, 1=frame complete, 2=streaming out
  int            mstate;
  int            wp;
  int            rp;
  int            drops;
  logic [SW-1:0] frame [FL];
  int            exp_idx [$];
  logic [SW-1:0] exp_dat [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_drop();
    if (drops < 65535) drops++;
  endtask

  task automatic step(input bit sv, input logic [SW-1:0] sin, input bit we, input bit wo, input bit rd);
    sample_valid = sv;
    sample_in    = sin;
    write_even   = we;
    write_odd    = wo;
    read         = rd;
    case (mstate)
      0: begin
        if (sv && ((wp % 2 == 1) ? wo : we)) begin
          frame[wp] = sin;
          wp++;
          if (wp == FL) begin
            wp = 0;
            mstate = 1;
          end
        end else if (sv) begin
          model_drop();
        end
      end
      1: begin
        if (sv) model_drop();
        if (rd) begin
          mstate = 2;
          rp = 0;
        end
      end
      default: begin
        if (sv) model_drop();
        if (rd) begin
          exp_idx.push_back(rp);
          exp_dat.push_back(frame[rp]);
          rp++;
          if (rp == FL) begin
            mstate = 0;
            wp = 0;
          end
        end
      end
    endcase
    @(posedge clk);
    #1;
    check("full_even", full_even, (mstate != 0) || (wp == FL - 1));
    check("full_odd", full_odd, mstate != 0);
  endtask

  task automatic check_outputs_zero();
    check("rst_full_even", full_even, 0);
    check("rst_full_odd", full_odd, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_index", rd_index, 0);
`ifdef SPB_DROP_CNT_EN
    check("rst_drop_count", drop_count, 0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    exp_idx.delete();
    exp_dat.delete();
    mstate = 0;
    wp = 0;
    rp = 0;
    drops = 0;
    check_outputs_zero();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic fill_frame(input int mode);
    int n = 0;
    int stall = 0;
    while (mstate == 0 && n < 20000) begin
      if (mode == 0)
        step(1'b1, SW'(wp), 1'b1, 1'b1, 1'b0);
      else if (wp == 7 && stall < 3) begin
        step(1'b1, SW'($urandom), 1'b1, 1'b0, 1'b0);
        stall++;
      end else
        step($urandom % 4 != 0, SW'($urandom), $urandom % 8 != 0, $urandom % 8 != 0, 1'b0);
      n++;
    end
    if (mstate != 1) begin
      tests++;
      fails++;
      $display("FAIL fill_timeout: actual %0d cycles required frame complete", n);
    end
  endtask

  task automatic drain_frame(input int mode, input int reset_at);
    int n = 0;
    bit rd;
    bit sv;
    while (mstate != 0 && n < 20000) begin
      if (reset_at >= 0 && mstate == 2 && rp == reset_at) begin
        do_reset();
        return;
      end
      case (mode)
        0:       rd = 1'b1;
        1:       rd = (n % 2 == 0);
        default: rd = ($urandom % 3 != 0);
      endcase
      sv = (mode == 0 && n == 0) ? 1'b1 : ($urandom % 8 == 0);
      step(sv, SW'($urandom), 1'b1, 1'b1, rd);
      n++;
    end
    if (mstate != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: actual %0d cycles required frame drained", n);
    end
    repeat (3) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("drain_leftover", exp_idx.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && rd_valid === 1'b1) begin
      if (exp_idx.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: actual index %0d required no output", rd_index);
      end else begin
        check("rd_index", rd_index, exp_idx.pop_front());
        check("rd_data", rd_data, exp_dat.pop_front());
      end
    end
  end

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    write_even   = 1'b0;
    write_odd    = 1'b0;
    read         = 1'b0;
    mstate       = 0;
    wp           = 0;
    rp           = 0;
    drops        = 0;
    #12;
    check_outputs_zero();
    @(posedge clk);
    #1;
    reset = 1'b0;

    fill_frame(0);
    drain_frame(0, -1);
    fill_frame(1);
    drain_frame(1, -1);
    fill_frame(1);
    drain_frame(2, 100);
    fill_frame(0);
    drain_frame(2, -1);
    fill_frame(1);
    drain_frame(0, -1);

`ifdef SPB_DROP_CNT_EN
    do_reset();
    fill_frame(0);
    repeat (10) step(1'b1, SW'($urandom), 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    repeat (5) step(1'b1, SW'($urandom), 1'b1, 1'b1, 1'b1);
    check("drop_count_15", drop_count, drops);
    drain_frame(0, -1);
    fill_frame(0);
    repeat (70000) step(1'b1, SW'($urandom), 1'b1, 1'b1, 1'b0);
    check("drop_count_sat", drop_count, drops);
    drain_frame(0, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
